seg_display_ctrl: RTL and testbench

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_display_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_ctrl
// Description : Round-robin arbitrated binary-to-BCD converter (double dabble)
//               driving a multiplexed 4-digit active-low 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [12:0] val0,
    input  logic [12:0] val1,
    input  logic [12:0] val2,
    output logic [2:0]  ack,
    output logic        busy,
    output logic [1:0]  src,
    input  logic        blank,
    input  logic        lz_blank,
    output logic [3:0]  anode,
    output logic [6:0]  led_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [REFRESH_BITS-1:0] REF_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [1:0]              ptr_q;
    logic [1:0]              gnt_q;
    logic [2:0]              ack_q;
    logic                    busy_q;
    logic [1:0]              src_q;
    logic [12:0]             shreg_q;
    logic [15:0]             bcd_q;
    logic [3:0]              bitcnt_q;
    logic [15:0]             disp_q;
    logic [REFRESH_BITS-1:0] refresh_q;

    logic        gnt_found_d;
    logic [1:0]  gnt_idx_d;
    logic [12:0] gnt_val_d;
    logic [1:0]  cand1_d;
    logic [1:0]  cand2_d;
    logic [15:0] bcd_adj_d;
    logic [28:0] shift_d;

    function automatic logic [1:0] next_mod3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Round-robin search starting at the pointer.
    always_comb begin
        cand1_d     = next_mod3(ptr_q);
        cand2_d     = next_mod3(cand1_d);
        gnt_found_d = 1'b1;
        gnt_idx_d   = ptr_q;
        if (req[ptr_q]) begin
            gnt_idx_d = ptr_q;
        end else if (req[cand1_d]) begin
            gnt_idx_d = cand1_d;
        end else if (req[cand2_d]) begin
            gnt_idx_d = cand2_d;
        end else begin
            gnt_found_d = 1'b0;
        end
        case (gnt_idx_d)
            2'd0:    gnt_val_d = val0;
            2'd1:    gnt_val_d = val1;
            default: gnt_val_d = val2;
        endcase
    end

    // Double-dabble step: add-3 correction then shift the whole chain.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bcd_adj_d[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                            : bcd_q[4*k +: 4];
        end
        shift_d = {bcd_adj_d, shreg_q} << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 2'd0;
            ack_q     <= 3'b000;
            busy_q    <= 1'b0;
            src_q     <= 2'd0;
            shreg_q   <= 13'd0;
            bcd_q     <= 16'd0;
            bitcnt_q  <= 4'd0;
            disp_q    <= 16'd0;
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + REF_ONE;
            ack_q     <= 3'b000;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_d) begin
                        gnt_q    <= gnt_idx_d;
                        ptr_q    <= next_mod3(gnt_idx_d);
                        ack_q    <= 3'(3'b001 << gnt_idx_d);
                        busy_q   <= 1'b1;
                        shreg_q  <= gnt_val_d;
                        bcd_q    <= 16'd0;
                        bitcnt_q <= 4'd0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q    <= shift_d[28:13];
                    shreg_q  <= shift_d[12:0];
                    bitcnt_q <= bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd12) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    disp_q  <= bcd_q;
                    src_q   <= gnt_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign src  = src_q;

    logic [1:0] sel_d;
    logic [3:0] digit_d;
    logic [3:0] an_d;
    logic       lz_d;
    logic [6:0] seg_d;

    // Scan multiplexer; a digit is a leading zero if it and every higher digit is 0.
    always_comb begin
        sel_d = refresh_q[REFRESH_BITS-1 -: 2];
        case (sel_d)
            2'b00: begin
                digit_d = disp_q[15:12];
                an_d    = 4'b0111;
                lz_d    = (disp_q[15:12] == 4'd0);
            end
            2'b01: begin
                digit_d = disp_q[11:8];
                an_d    = 4'b1011;
                lz_d    = (disp_q[15:8] == 8'd0);
            end
            2'b10: begin
                digit_d = disp_q[7:4];
                an_d    = 4'b1101;
                lz_d    = (disp_q[15:4] == 12'd0);
            end
            default: begin
                digit_d = disp_q[3:0];
                an_d    = 4'b1110;
                lz_d    = 1'b0;
            end
        endcase
        case (digit_d)
            4'd0:    seg_d = 7'b0000001;
            4'd1:    seg_d = 7'b1001111;
            4'd2:    seg_d = 7'b0010010;
            4'd3:    seg_d = 7'b0000110;
            4'd4:    seg_d = 7'b1001100;
            4'd5:    seg_d = 7'b0100100;
            4'd6:    seg_d = 7'b0100000;
            4'd7:    seg_d = 7'b0001111;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0000100;
            default: seg_d = 7'b1111111;
        endcase
        if (lz_blank && lz_d) begin
            seg_d = 7'b1111111;
        end
    end

    assign anode   = blank ? 4'b1111 : an_d;
    assign led_out = seg_d;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_ctrl
// Description : Scoreboard bench for seg_display_ctrl with REFRESH_BITS = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [12:0] val0, val1, val2;
    logic        blank, lz_blank;
    logic [2:0]  ack;
    logic        busy;
    logic [1:0]  src;
    logic [3:0]  anode;
    logic [6:0]  led_out;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [1:0]  src;
        logic [15:0] dig;
    } exp_t;
    exp_t sb[$];

    seg_display_ctrl #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .ack(ack), .busy(busy), .src(src),
        .blank(blank), .lz_blank(lz_blank),
        .anode(anode), .led_out(led_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_led(input logic [15:0] dig, input int pos, input logic lz);
        logic allz;
        allz = 1'b1;
        for (int j = pos; j < 4; j++) if (dig[4*j +: 4] != 4'd0) allz = 1'b0;
        if (lz && pos != 0 && allz) return 7'b1111111;
        return seg_ref(dig[4*pos +: 4]);
    endfunction

    function automatic int anode_pos(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_display(input logic [15:0] dig, input logic lz, input string tag);
        int p;
        for (int i = 0; i < 16; i++) begin
            p = anode_pos(anode);
            nvec++;
            if (p < 0 || led_out !== exp_led(dig, (p < 0) ? 0 : p, lz)) begin
                nerr++;
                $display("FAIL %s scan: anode=%b led_out=%b, required digits=%h lz=%0b", tag, anode, led_out, dig, lz);
            end
            tick();
        end
    endtask

    // Issues one request, checks ack and busy length, then pops and checks the display.
    task automatic run_conversion(input int idx, input int v, input logic lz,
                                  input logic hold, input logic [15:0] prev, input string tag);
        int   n;
        int   p;
        exp_t e;
        logic [1:0] i2;
        i2 = 2'(idx);
        case (idx)
            0: val0 = 13'(v);
            1: val1 = 13'(v);
            default: val2 = 13'(v);
        endcase
        sb.push_back({i2, to_bcd(v)});
        req[idx] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === 3'b000 && n < 20);
        nvec++;
        if (ack !== 3'(3'b001 << idx)) begin
            nerr++;
            $display("FAIL %s ack: got %b, required %b", tag, ack, 3'(3'b001 << idx));
        end
        req[idx] = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (hold) begin
                p = anode_pos(anode);
                nvec++;
                if (p < 0 || led_out !== exp_led(prev, (p < 0) ? 0 : p, lz)) begin
                    nerr++;
                    $display("FAIL %s hold: anode=%b led_out=%b, required old digits=%h", tag, anode, led_out, prev);
                end
            end
            tick();
        end
        nvec++;
        if (n != 14) begin
            nerr++;
            $display("FAIL %s busy_len: got %0d cycles, required 14", tag, n);
        end
        e = sb.pop_front();
        nvec++;
        if (src !== e.src) begin
            nerr++;
            $display("FAIL %s src: got %0d, required %0d", tag, src, e.src);
        end
        check_display(e.dig, lz, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 3'b000; val0 = '0; val1 = '0; val2 = '0;
        blank = 1'b0; lz_blank = 1'b0;
        #3;
        nvec++;
        if (busy !== 1'b0 || ack !== 3'b000 || src !== 2'd0) begin
            nerr++;
            $display("FAIL reset_ctrl: busy=%b ack=%b src=%0d, required 0 000 0", busy, ack, src);
        end
        tick(); tick(); tick();
        nvec++;
        if (anode !== 4'b0111 || led_out !== 7'b0000001) begin
            nerr++;
            $display("FAIL reset_disp: anode=%b led_out=%b, required 0111 0000001", anode, led_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_convert();
        run_conversion(0, 8191, 1'b0, 1'b0, 16'h0000, "conv8191");
    endtask

    task automatic test_round_robin();
        logic [2:0] order[4];
        int         when[4];
        int         k = 0;
        int         cyc = 0;
        logic [2:0] exp_order[4];
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst = 1'b1; #2; rst = 1'b0;
        val0 = 13'd100; val1 = 13'd200; val2 = 13'd300;
        req = 3'b111;
        while (k < 4 && cyc < 100) begin
            tick();
            cyc++;
            if (ack !== 3'b000) begin
                order[k] = ack;
                when[k]  = cyc;
                k++;
            end
        end
        req = 3'b000;
        nvec++;
        if (k != 4) begin
            nerr++;
            $display("FAIL rr_count: got %0d acks, required 4", k);
        end
        for (int i = 0; i < k; i++) begin
            nvec++;
            if (order[i] !== exp_order[i] || (i > 0 && when[i] - when[i-1] != 15)) begin
                nerr++;
                $display("FAIL rr_ack%0d: got %b after %0d cycles, required %b after 15", i, order[i],
                         (i > 0) ? when[i] - when[i-1] : 0, exp_order[i]);
            end
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        nvec++;
        if (busy !== 1'b0 || src !== 2'd0) begin
            nerr++;
            $display("FAIL rr_final: busy=%b src=%0d, required 0 0", busy, src);
        end
    endtask

    task automatic test_leading_zero();
        lz_blank = 1'b1;
        run_conversion(1, 7, 1'b1, 1'b0, 16'h0000, "lz7");
        run_conversion(1, 0, 1'b1, 1'b0, 16'h0000, "lz0");
        lz_blank = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_conversion(2, 1234, 1'b0, 1'b0, 16'h0000, "load1234");
        run_conversion(2, 5678, 1'b0, 1'b1, 16'h1234, "hold5678");
    endtask

    task automatic test_abort();
        int   n;
        exp_t e;
        val0 = 13'd4095;
        req  = 3'b001;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === 3'b000 && n < 20);
        nvec++;
        if (ack !== 3'b001) begin
            nerr++;
            $display("FAIL abort_ack1: got %b, required 001", ack);
        end
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || ack !== 3'b000 || anode !== 4'b0111 || led_out !== 7'b0000001 || src !== 2'd0) begin
            nerr++;
            $display("FAIL abort_rst: busy=%b ack=%b anode=%b led_out=%b src=%0d, required 0 000 0111 0000001 0",
                     busy, ack, anode, led_out, src);
        end
        #1;
        rst = 1'b0;
        sb.push_back({2'd0, to_bcd(4095)});
        n = 0;
        do begin
            tick();
            n++;
        end while (ack === 3'b000 && n < 20);
        nvec++;
        if (ack !== 3'b001 || n != 1) begin
            nerr++;
            $display("FAIL abort_regrant: got ack %b after %0d cycles, required 001 after 1", ack, n);
        end
        req = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        nvec++;
        if (n != 14) begin
            nerr++;
            $display("FAIL abort_busy_len: got %0d, required 14", n);
        end
        e = sb.pop_front();
        check_display(e.dig, 1'b0, "abort4095");
    endtask

    task automatic test_blank();
        logic [3:0] prev;
        logic [3:0] pats[4];
        int         n;
        pats = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        blank = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (anode !== 4'b1111) begin
                nerr++;
                $display("FAIL blank_on: anode=%b, required 1111", anode);
            end
            tick();
        end
        blank = 1'b0;
        #1;
        prev = anode;
        n = 0;
        do begin
            prev = anode;
            tick();
            n++;
        end while (!(anode === 4'b0111 && prev === 4'b1110) && n < 20);
        nvec++;
        if (n >= 20) begin
            nerr++;
            $display("FAIL blank_sync: anode scan start not found, last anode=%b", anode);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (anode !== pats[i/4]) begin
                nerr++;
                $display("FAIL blank_scan%0d: anode=%b, required %b", i, anode, pats[i/4]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_convert();
        test_round_robin();
        test_leading_zero();
        test_back_to_back();
        test_abort();
        test_blank();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
